// File: rtl/data_ram_responder.sv
// Word-addressed data RAM behind a req/addr_ok/data_ok handshake, with a fixed
// request-to-response latency and byte-strobed writes committed at response end.
module data_ram_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         mem [2**ADDR_W];

  // Byte offset and bits above the index never select storage.
  logic unused_addr;
  assign unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          wr_d    = wr;
          wstrb_d = wstrb;
          wdata_d = wdata;
          idx_d   = addr[ADDR_W+1:2];
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage is deliberately not reset; a reset drops the state to IDLE first,
  // so an interrupted write never reaches this commit.
  always_ff @(posedge clk) begin
    if (state_q == RESP && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    addr_ok = (state_q == IDLE);
    busy    = (state_q != IDLE);
    data_ok = (state_q == RESP);
    rdata   = (state_q == RESP && !wr_q) ? mem[idx_q] : '0;
  end

endmodule
